fast_inlier_tally: RTL and testbench
====================================

# fast_inlier_tally

Streaming consumer of per-point signed distances produced by the dot-product / point-to-plane stage. Classifies each distance against a threshold, counts inliers per candidate plane, emits one tally per point set through a ready/valid port, and tracks the best plane of the current RANSAC run. Accepts one sample per cycle with no backpressure on its input, matching the upstream fixed-latency pipeline.

## Interface
Parameters:
- count_bits, 16, width of inlier counters (saturating)
- plane_id_bits, 8, width of candidate plane identifier

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous start of a new RANSAC run
- threshold  in  fixed_t  inlier bound, treated as non-negative; sampled per sample
- sample_valid  in  1  distance/last/id qualify this cycle
- distance  in  fixed_t  signed distance (two's complement)
- sample_last  in  1  final point of current set
- sample_plane_id  in  plane_id_bits  candidate id; value on the last sample is used
- result_valid  out  1  tally available
- result_ready  in  1  consumer accepts tally
- result_plane_id  out  plane_id_bits  id of head tally
- result_count  out  count_bits  inlier count of head tally
- best_valid  out  1  at least one tally completed since clear/reset
- best_plane_id  out  plane_id_bits  id with highest count so far
- best_count  out  count_bits  that count
- overrun  out  1  sticky: a tally was dropped because output storage was full

## Operation
- Stage 1 (registered): mag = |distance|; most-negative value saturates to fixed_t max. inlier = (mag <= threshold). Carries valid, last, plane_id.
- Stage 2 (registered): running count += inlier, saturating at 2^count_bits-1. On a stage-1 last: tally = count + inlier (saturating), running count returns to 0 in the same edge, tally pushed to output FIFO.
- Set of length 1 (last on first sample) is legal; tally is 0 or 1.
- Output FIFO: 2 entries, head drives result_*. Pop when result_valid && result_ready. Push and pop in same cycle when full: both occur, no drop.
- Push while full without pop: tally dropped, overrun set; best tracking still updated with the dropped tally.
- Best update at push time: replace if !best_valid or tally > best_count (strict; ties keep earlier plane).
- clear: flushes stage registers, running count, FIFO, best_valid, overrun; any sample presented with clear is discarded. clear has priority over all other events.
- Gaps (sample_valid low) inside a set are permitted; count holds.

## Timing
- Reset values: result_valid 0, result_plane_id 0, result_count 0, best_valid 0, best_plane_id 0, best_count 0, overrun 0; internal count 0, FIFO empty.
- Latency: last sample presented in cycle t → result_valid high in cycle t+2 (if FIFO was empty); best_* updated in same cycle t+2.
- Throughput: one sample per cycle; back-to-back sets (last followed immediately by next set's first sample) need no idle cycle.
- result_* stable while result_valid && !result_ready.
- reset_n assertion mid-set discards all state immediately; outputs take reset values asynchronously.

## Structure
- ransac_fixed package gains: inlier_tally_t struct {plane_id, count} (parameterised widths via localparams there) and function fixed_abs_saturate(fixed_t) → fixed_t.
- One sub-module: inlier_result_fifo, 2-entry ready/valid FIFO of inlier_tally_t with full/push/pop, async active-low reset.
- Top holds the two pipeline stages, saturating counter, best tracker, overrun flag.

## Test plan
- threshold 0.5; set of 4 distances {0.25, -0.5, 0.75, -1.0}, id 3, ready high → result count 2, id 3 at t+2; best_count 2, best_plane_id 3.
- distance = most-negative fixed_t, threshold = fixed_t max → counted as inlier (count 1).
- count_bits=4, 20 inlier samples in one set → result_count 15 (saturated).
- ready held low, three back-to-back single-sample sets ids 1,2,3 all inliers → first two held in FIFO, third dropped, overrun 1; best stays id 1 (tie); ready high drains ids 1,2 in order.
- sets id 5 count 7 then id 6 count 9 then id 7 count 9 → best_plane_id 6, best_count 9; then clear → best_valid 0, overrun 0, result_valid 0 next cycle.
- reset_n pulsed low mid-set after 3 inliers, then new set of 2 inliers → single result count 2, no stale tally.

Source files
------------

// File: rtl/ransac_fixed_pkg.sv
// Shared fixed-point types for the RANSAC plane-fit datapath (Q8.8 signed distances)
// plus the inlier tally record carried from the tally stage to its consumer.
package ransac_fixed;

    localparam int FIXED_BITS = 16;

    typedef logic signed [FIXED_BITS-1:0] fixed_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_BITS-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_BITS-1){1'b0}}};

    // Storage widths of a tally; instances may use narrower counters/ids.
    localparam int TALLY_COUNT_BITS = 16;
    localparam int TALLY_ID_BITS    = 8;

    typedef struct packed {
        logic [TALLY_ID_BITS-1:0]    plane_id;
        logic [TALLY_COUNT_BITS-1:0] count;
    } inlier_tally_t;

    // The most-negative value has no positive twin, so it clamps to the max.
    function automatic fixed_t fixed_abs_saturate(input fixed_t value);
        fixed_t result;
        if (value == FIXED_MIN) begin
            result = FIXED_MAX;
        end else if (value[FIXED_BITS-1]) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/inlier_result_fifo.sv
// Two-entry ready/valid FIFO of inlier tallies. A push into a full FIFO is
// only accepted when a pop happens in the same cycle.
module inlier_result_fifo
    import ransac_fixed::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  inlier_tally_t push_data,
    input  logic          pop,
    output logic          valid,
    output inlier_tally_t head,
    output logic          full
);

    inlier_tally_t mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    level;
    logic          do_pop;
    logic          do_push;

    assign valid   = (level != 2'd0);
    assign full    = (level == 2'd2);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            level  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fast_inlier_tally.sv
// Classifies streamed point-to-plane distances against a threshold, tallies
// inliers per candidate plane and tracks the best plane of the current run.
module fast_inlier_tally
    import ransac_fixed::*;
#(
    parameter int count_bits    = 16,
    parameter int plane_id_bits = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  fixed_t                   threshold,
    input  logic                     sample_valid,
    input  fixed_t                   distance,
    input  logic                     sample_last,
    input  logic [plane_id_bits-1:0] sample_plane_id,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [plane_id_bits-1:0] result_plane_id,
    output logic [count_bits-1:0]    result_count,
    output logic                     best_valid,
    output logic [plane_id_bits-1:0] best_plane_id,
    output logic [count_bits-1:0]    best_count,
    output logic                     overrun
);

    localparam logic [count_bits-1:0] COUNT_MAX = '1;

    fixed_t                   mag;
    logic                     s1_valid;
    logic                     s1_last;
    logic                     s1_inlier;
    logic [plane_id_bits-1:0] s1_plane_id;
    logic [count_bits-1:0]    run_count;
    logic [count_bits-1:0]    tally_count;
    logic                     tally_push;
    logic                     fifo_full;
    logic                     fifo_pop;
    inlier_tally_t            push_data;
    inlier_tally_t            head;
    logic                     unused_head;

    assign mag = fixed_abs_saturate(distance);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_inlier   <= 1'b0;
            s1_plane_id <= '0;
        end else if (clear) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_inlier   <= 1'b0;
            s1_plane_id <= '0;
        end else begin
            s1_valid    <= sample_valid;
            s1_last     <= sample_valid && sample_last;
            s1_inlier   <= sample_valid && ($unsigned(mag) <= $unsigned(threshold));
            s1_plane_id <= sample_plane_id;
        end
    end

    // Count including the current stage-1 sample, held at all-ones once saturated.
    always_comb begin
        tally_count = run_count;
        if (s1_inlier && (run_count != COUNT_MAX)) begin
            tally_count = run_count + count_bits'(1);
        end
    end

    assign tally_push = s1_valid && s1_last && !clear;
    assign fifo_pop   = result_valid && result_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_count <= '0;
        end else if (clear) begin
            run_count <= '0;
        end else if (s1_valid) begin
            run_count <= s1_last ? '0 : tally_count;
        end
    end

    always_comb begin
        push_data          = '0;
        push_data.plane_id = TALLY_ID_BITS'(s1_plane_id);
        push_data.count    = TALLY_COUNT_BITS'(tally_count);
    end

    inlier_result_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (clear),
        .push      (tally_push),
        .push_data (push_data),
        .pop       (result_ready),
        .valid     (result_valid),
        .head      (head),
        .full      (fifo_full)
    );

    assign result_plane_id = head.plane_id[plane_id_bits-1:0];
    assign result_count    = head.count[count_bits-1:0];
    assign unused_head     = ^head;

    // Best tracking sees every completed tally, including ones the FIFO drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            best_valid    <= 1'b0;
            best_plane_id <= '0;
            best_count    <= '0;
            overrun       <= 1'b0;
        end else if (clear) begin
            best_valid    <= 1'b0;
            best_plane_id <= '0;
            best_count    <= '0;
            overrun       <= 1'b0;
        end else if (tally_push) begin
            if (!best_valid || (tally_count > best_count)) begin
                best_valid    <= 1'b1;
                best_plane_id <= s1_plane_id;
                best_count    <= tally_count;
            end
            if (fifo_full && !fifo_pop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fast_inlier_tally.sv
// Scoreboard bench: expected tallies are queued as sets are sent and a monitor
// compares them whenever the DUT hands over a result.
module tb_fast_inlier_tally;
    import ransac_fixed::*;

    typedef struct {
        int id;
        int count;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       clear;
    fixed_t     threshold;
    logic       sample_valid;
    fixed_t     distance;
    logic       sample_last;
    logic [7:0] sample_plane_id;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result_plane_id;
    logic [3:0] result_count;
    logic       best_valid;
    logic [7:0] best_plane_id;
    logic [3:0] best_count;
    logic       overrun;

    exp_t sb[$];
    int   pass_count = 0;
    int   check_count = 0;

    fast_inlier_tally #(.count_bits(4), .plane_id_bits(8)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear           (clear),
        .threshold       (threshold),
        .sample_valid    (sample_valid),
        .distance        (distance),
        .sample_last     (sample_last),
        .sample_plane_id (sample_plane_id),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_plane_id (result_plane_id),
        .result_count    (result_count),
        .best_valid      (best_valid),
        .best_plane_id   (best_plane_id),
        .best_count      (best_count),
        .overrun         (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input fixed_t d, input logic l, input int id);
        sample_valid    = v;
        distance        = d;
        sample_last     = l;
        sample_plane_id = 8'(id);
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        sample_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clearRun();
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    // Inliers (distance 0) first, then outliers (4.0), last flag on the final sample.
    task automatic sendSet(input int id, input int n_in, input int n_out, input int expected);
        int total;
        total = n_in + n_out;
        sb.push_back('{id, expected});
        for (int i = 0; i < total; i++) begin
            applyStimulus(1'b1, (i < n_in) ? 16'sh0000 : 16'sh0400, (i == total - 1), id);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                check_count++;
                $display("[TB] FAIL unexpected_tally: got id %0d count %0d, expected none",
                         result_plane_id, result_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("tally_id", int'(result_plane_id), e.id);
                checkOutput("tally_count", int'(result_count), e.count);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        clear           = 1'b0;
        threshold       = 16'sd128;
        sample_valid    = 1'b0;
        distance        = '0;
        sample_last     = 1'b0;
        sample_plane_id = '0;
        result_ready    = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rst_result_valid", int'(result_valid), 0);
        checkOutput("rst_result_id", int'(result_plane_id), 0);
        checkOutput("rst_result_count", int'(result_count), 0);
        checkOutput("rst_best_valid", int'(best_valid), 0);
        checkOutput("rst_best_id", int'(best_plane_id), 0);
        checkOutput("rst_best_count", int'(best_count), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        idle(1);

        // Threshold 0.5: {0.25, gap, -0.5, 0.75, -1.0} gives 2 inliers.
        sb.push_back('{3, 2});
        applyStimulus(1'b1, 16'sd64, 1'b0, 3);
        applyStimulus(1'b0, 16'sd0, 1'b0, 0);
        applyStimulus(1'b1, -16'sd128, 1'b0, 3);
        applyStimulus(1'b1, 16'sd192, 1'b0, 3);
        applyStimulus(1'b1, -16'sd256, 1'b1, 3);
        checkOutput("latency_t1_valid", int'(result_valid), 0);
        idle(1);
        checkOutput("latency_t2_valid", int'(result_valid), 1);
        checkOutput("t2_best_valid", int'(best_valid), 1);
        checkOutput("t2_best_id", int'(best_plane_id), 3);
        checkOutput("t2_best_count", int'(best_count), 2);
        idle(2);

        // Most-negative distance against max threshold counts as an inlier.
        threshold = 16'sh7FFF;
        sb.push_back('{9, 1});
        applyStimulus(1'b1, 16'sh8000, 1'b1, 9);
        idle(3);
        checkOutput("minneg_best_id", int'(best_plane_id), 3);
        checkOutput("minneg_best_count", int'(best_count), 2);

        // 20 inliers into a 4-bit counter saturate at 15.
        sb.push_back('{10, 15});
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 16'sd0, 1'b0, 10);
        applyStimulus(1'b1, 16'sd0, 1'b1, 10);
        idle(3);
        checkOutput("sat_best_id", int'(best_plane_id), 10);
        checkOutput("sat_best_count", int'(best_count), 15);
        checkOutput("sat_drained", sb.size(), 0);

        // Ready low: ids 1,2 held, id 3 dropped, tie keeps id 1.
        clearRun();
        threshold    = 16'sd128;
        result_ready = 1'b0;
        sb.push_back('{1, 1});
        sb.push_back('{2, 1});
        applyStimulus(1'b1, 16'sd0, 1'b1, 1);
        applyStimulus(1'b1, 16'sd0, 1'b1, 2);
        applyStimulus(1'b1, 16'sd0, 1'b1, 3);
        idle(3);
        checkOutput("ovf_overrun", int'(overrun), 1);
        checkOutput("ovf_best_id", int'(best_plane_id), 1);
        checkOutput("ovf_best_count", int'(best_count), 1);
        checkOutput("ovf_result_valid", int'(result_valid), 1);
        checkOutput("ovf_head_id", int'(result_plane_id), 1);
        idle(2);
        checkOutput("ovf_head_stable", int'(result_plane_id), 1);
        result_ready = 1'b1;
        idle(4);
        checkOutput("ovf_drained", sb.size(), 0);
        checkOutput("ovf_empty_valid", int'(result_valid), 0);

        // Counts 7, 9, 9: strict comparison keeps id 6.
        clearRun();
        sendSet(5, 7, 1, 7);
        sendSet(6, 9, 0, 9);
        sendSet(7, 9, 2, 9);
        idle(4);
        checkOutput("best_id_6", int'(best_plane_id), 6);
        checkOutput("best_count_9", int'(best_count), 9);
        checkOutput("best_drained", sb.size(), 0);
        result_ready = 1'b0;
        applyStimulus(1'b1, 16'sd0, 1'b1, 20);
        applyStimulus(1'b1, 16'sd0, 1'b1, 21);
        applyStimulus(1'b1, 16'sd0, 1'b1, 22);
        idle(3);
        checkOutput("pre_clear_overrun", int'(overrun), 1);
        checkOutput("pre_clear_valid", int'(result_valid), 1);
        clear           = 1'b1;
        sample_valid    = 1'b1;
        sample_last     = 1'b1;
        distance        = 16'sd0;
        sample_plane_id = 8'd30;
        @(posedge clock);
        #1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample_last  = 1'b0;
        checkOutput("clear_best_valid", int'(best_valid), 0);
        checkOutput("clear_overrun", int'(overrun), 0);
        checkOutput("clear_result_valid", int'(result_valid), 0);
        idle(3);
        checkOutput("clear_sample_discarded", int'(result_valid), 0);
        checkOutput("clear_best_still_invalid", int'(best_valid), 0);
        result_ready = 1'b1;

        // Reset mid-set discards the partial count of 3.
        sendSet(11, 1, 0, 1);
        idle(3);
        checkOutput("prerst_best_valid", int'(best_valid), 1);
        applyStimulus(1'b1, 16'sd0, 1'b0, 12);
        applyStimulus(1'b1, 16'sd0, 1'b0, 12);
        applyStimulus(1'b1, 16'sd0, 1'b0, 12);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_best_valid", int'(best_valid), 0);
        checkOutput("async_rst_best_count", int'(best_count), 0);
        checkOutput("async_rst_result_valid", int'(result_valid), 0);
        #2;
        reset_n = 1'b1;
        sendSet(12, 2, 0, 2);
        idle(4);
        checkOutput("postrst_best_id", int'(best_plane_id), 12);
        checkOutput("postrst_best_count", int'(best_count), 2);
        checkOutput("final_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
